// File: rtl/mbist_fail_log.sv
// rtl/mbist_fail_log.sv - MBIST compare-event fail logger with verdict, counters and readout FIFO
module mbist_fail_log #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 4,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                              CLK,
    input  logic                              nRESET,
    input  logic                              MBISTEN,
    input  logic                              TEST_START,
    input  logic                              TEST_END,
    input  logic                              CMP_VALID,
    input  logic [ADDR_W-1:0]                 CMP_ADDR,
    input  logic [DATA_W-1:0]                 CMP_EXP,
    input  logic [DATA_W-1:0]                 CMP_ACT,
    input  logic [PHASE_W-1:0]                CMP_PHASE,
    output logic                              LOG_VALID,
    input  logic                              LOG_READY,
    output logic [PHASE_W+ADDR_W+DATA_W-1:0]  LOG_DATA,
    output logic [CNT_W-1:0]                  FAIL_CNT,
    output logic [ADDR_W-1:0]                 FIRST_ADDR,
    output logic                              OVERFLOW,
    output logic                              BUSY,
    output logic                              DONE,
    output logic                              PASS
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = PHASE_W + ADDR_W + DATA_W;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;
    logic [ADDR_W-1:0]   first_addr_q, first_addr_d;
    logic                overflow_q, overflow_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [ENTRY_W-1:0]  mem_q [DEPTH];

    logic start_w, take_w, fail_w, full_w, pop_w, push_w;
    logic [ENTRY_W-1:0] entry_w;

    // A start restarts the test; any compare or pop in that cycle is discarded.
    assign start_w = TEST_START & MBISTEN;
    assign take_w  = (state_q == ST_RUN) & MBISTEN & CMP_VALID & ~start_w;
    assign fail_w  = take_w & (CMP_ACT != CMP_EXP);
    assign full_w  = (count_q == FULL_CNT);
    assign pop_w   = (count_q != '0) & LOG_READY & ~start_w;
    assign push_w  = fail_w & (~full_w | pop_w);
    assign entry_w = {CMP_PHASE, CMP_ADDR, CMP_EXP ^ CMP_ACT};

    // Next-state logic: losing MBISTEN always parks the logger in IDLE.
    always_comb begin
        state_d = state_q;
        if (!MBISTEN) begin
            state_d = ST_IDLE;
        end else if (TEST_START) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && TEST_END) begin
            state_d = ST_DONE;
        end
    end

    // Next values for counters, first-fail address, overflow flag and FIFO pointers.
    always_comb begin
        fail_cnt_d   = fail_cnt_q;
        first_addr_d = first_addr_q;
        overflow_d   = overflow_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (start_w) begin
            fail_cnt_d   = '0;
            first_addr_d = '0;
            overflow_d   = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
        end else begin
            if (fail_w) begin
                if (fail_cnt_q != CNT_MAX) begin
                    fail_cnt_d = fail_cnt_q + CNT_W'(1);
                end
                if (fail_cnt_q == '0) begin
                    first_addr_d = CMP_ADDR;
                end
                if (full_w && !pop_w) begin
                    overflow_d = 1'b1;
                end
            end
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_w && !pop_w) begin
                count_d = count_q + (PTR_W+1)'(1);
            end else if (pop_w && !push_w) begin
                count_d = count_q - (PTR_W+1)'(1);
            end
        end
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= ST_IDLE;
            fail_cnt_q   <= '0;
            first_addr_q <= '0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fail_cnt_q   <= fail_cnt_d;
            first_addr_q <= first_addr_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage; contents need no reset since reads are masked when empty.
    always_ff @(posedge CLK) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= entry_w;
        end
    end

    assign LOG_VALID  = (count_q != '0);
    assign LOG_DATA   = LOG_VALID ? mem_q[rd_ptr_q] : '0;
    assign FAIL_CNT   = fail_cnt_q;
    assign FIRST_ADDR = first_addr_q;
    assign OVERFLOW   = overflow_q;
    assign BUSY       = (state_q == ST_RUN);
    assign DONE       = (state_q == ST_DONE);
    assign PASS       = (state_q == ST_DONE) && (fail_cnt_q == '0);
endmodule

// File: tb/tb_mbist_fail_log.sv
// tb/tb_mbist_fail_log.sv - scoreboard testbench for mbist_fail_log
module tb_mbist_fail_log;
    logic        CLK = 1'b0;
    logic        nRESET;
    logic        MBISTEN, TEST_START, TEST_END, CMP_VALID, LOG_READY;
    logic [7:0]  CMP_ADDR, CMP_EXP, CMP_ACT;
    logic [3:0]  CMP_PHASE;
    logic        LOG_VALID, OVERFLOW, BUSY, DONE, PASS;
    logic [19:0] LOG_DATA;
    logic [15:0] FAIL_CNT;
    logic [7:0]  FIRST_ADDR;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;
    logic [19:0] exp_q[$];

    mbist_fail_log dut (
        .CLK(CLK), .nRESET(nRESET), .MBISTEN(MBISTEN), .TEST_START(TEST_START),
        .TEST_END(TEST_END), .CMP_VALID(CMP_VALID), .CMP_ADDR(CMP_ADDR),
        .CMP_EXP(CMP_EXP), .CMP_ACT(CMP_ACT), .CMP_PHASE(CMP_PHASE),
        .LOG_VALID(LOG_VALID), .LOG_READY(LOG_READY), .LOG_DATA(LOG_DATA),
        .FAIL_CNT(FAIL_CNT), .FIRST_ADDR(FIRST_ADDR), .OVERFLOW(OVERFLOW),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted readout is compared against the scoreboard head.
    always @(negedge CLK) begin
        if (nRESET && LOG_VALID && LOG_READY) begin
            n_pops++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL log_unexpected: got %0h expected no entry", LOG_DATA);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if (LOG_DATA !== e) begin
                    n_fail++;
                    $display("FAIL log_entry: got %0h expected %0h", LOG_DATA, e);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        TEST_START = 1'b1;
        cycle();
        TEST_START = 1'b0;
    endtask

    task automatic pulse_end();
        TEST_END = 1'b1;
        cycle();
        TEST_END = 1'b0;
    endtask

    task automatic cmp(input logic [7:0] a, input logic [7:0] e, input logic [7:0] x,
                       input logic [3:0] ph, input bit expect_logged);
        CMP_VALID = 1'b1;
        CMP_ADDR  = a;
        CMP_EXP   = e;
        CMP_ACT   = x;
        CMP_PHASE = ph;
        if (expect_logged) exp_q.push_back({ph, a, e ^ x});
        cycle();
        CMP_VALID = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        LOG_READY = 1'b1;
        while (LOG_VALID && n < 20) begin
            cycle();
            n++;
        end
        LOG_READY = 1'b0;
        chk({name, "_drained"}, {31'd0, LOG_VALID}, 32'd0);
        chk({name, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        nRESET = 1'b0; MBISTEN = 1'b0; TEST_START = 1'b0; TEST_END = 1'b0;
        CMP_VALID = 1'b0; LOG_READY = 1'b0;
        CMP_ADDR = '0; CMP_EXP = '0; CMP_ACT = '0; CMP_PHASE = '0;
        #2;
        chk("rst_log_valid", {31'd0, LOG_VALID}, 32'd0);
        chk("rst_log_data", {12'd0, LOG_DATA}, 32'd0);
        chk("rst_flags", {28'd0, OVERFLOW, BUSY, DONE, PASS}, 32'd0);
        chk("rst_cnt", {16'd0, FAIL_CNT}, 32'd0);
        cycle();
        nRESET = 1'b1;
        MBISTEN = 1'b1;
        cycle();

        // Clean run
        pulse_start();
        chk("clean_busy", {31'd0, BUSY}, 32'd1);
        for (int i = 0; i < 256; i++) cmp(8'(i), 8'h55, 8'h55, 4'd0, 1'b0);
        pulse_end();
        chk("clean_done_pass", {30'd0, DONE, PASS}, 32'd3);
        chk("clean_cnt", {16'd0, FAIL_CNT}, 32'd0);
        chk("clean_log_valid", {31'd0, LOG_VALID}, 32'd0);

        // Single fail
        pulse_start();
        cmp(8'h3C, 8'h00, 8'h04, 4'd2, 1'b1);
        pulse_end();
        chk("single_cnt", {16'd0, FAIL_CNT}, 32'd1);
        chk("single_first", {24'd0, FIRST_ADDR}, 32'h3C);
        chk("single_done_pass", {30'd0, DONE, PASS}, 32'd2);
        chk("single_log_data", {12'd0, LOG_DATA}, 32'h23C04);
        LOG_READY = 1'b1;
        cycle();
        LOG_READY = 1'b0;
        chk("single_popped", {31'd0, LOG_VALID}, 32'd0);

        // Overflow: 10 fails, last one together with TEST_END
        pulse_start();
        for (int i = 0; i < 9; i++) cmp(8'(i), 8'h00, 8'h81, 4'd1, i < 8);
        TEST_END = 1'b1;
        cmp(8'd9, 8'h00, 8'h81, 4'd1, 1'b0);
        TEST_END = 1'b0;
        chk("ovf_cnt", {16'd0, FAIL_CNT}, 32'd10);
        chk("ovf_flag", {31'd0, OVERFLOW}, 32'd1);
        chk("ovf_first", {24'd0, FIRST_ADDR}, 32'd0);
        chk("ovf_end_with_cmp_done", {31'd0, DONE}, 32'd1);
        n_pops = 0;
        drain("ovf");
        chk("ovf_pops", n_pops, 32'd8);

        // Full with simultaneous push and pop
        pulse_start();
        for (int i = 0; i < 8; i++) cmp(8'h10 + 8'(i), 8'hFF, 8'h0F, 4'd3, 1'b1);
        chk("full_no_ovf", {31'd0, OVERFLOW}, 32'd0);
        LOG_READY = 1'b1;
        cmp(8'hA0, 8'hFF, 8'hFE, 4'd5, 1'b1);
        LOG_READY = 1'b0;
        chk("full_pp_no_ovf", {31'd0, OVERFLOW}, 32'd0);
        chk("full_pp_cnt", {16'd0, FAIL_CNT}, 32'd9);
        n_pops = 0;
        drain("full_pp");
        chk("full_pp_remaining", n_pops, 32'd8);

        // Control corners: compare in DONE ignored, restart from DONE
        pulse_start();
        for (int i = 0; i < 3; i++) cmp(8'h40 + 8'(i), 8'h01, 8'h02, 4'd0, 1'b0);
        pulse_end();
        cmp(8'h50, 8'h01, 8'h03, 4'd0, 1'b0);
        chk("done_cmp_ignored", {16'd0, FAIL_CNT}, 32'd3);
        TEST_START = 1'b1;
        cmp(8'h51, 8'h01, 8'h03, 4'd0, 1'b0);
        TEST_START = 1'b0;
        chk("restart_cnt", {16'd0, FAIL_CNT}, 32'd0);
        chk("restart_fifo", {31'd0, LOG_VALID}, 32'd0);
        chk("restart_busy", {31'd0, BUSY}, 32'd1);

        // MBISTEN dropped mid-run; log still readable in IDLE
        cmp(8'h61, 8'h00, 8'hAA, 4'd7, 1'b1);
        cmp(8'h62, 8'h00, 8'h55, 4'd7, 1'b1);
        MBISTEN = 1'b0;
        cycle();
        chk("drop_state", {30'd0, BUSY, DONE}, 32'd0);
        chk("drop_cnt", {16'd0, FAIL_CNT}, 32'd2);
        chk("drop_first", {24'd0, FIRST_ADDR}, 32'h61);
        drain("idle_readout");
        MBISTEN = 1'b1;
        cmp(8'h63, 8'h00, 8'h01, 4'd0, 1'b0);
        chk("idle_cmp_ignored", {16'd0, FAIL_CNT}, 32'd2);

        // Asynchronous reset mid-run
        pulse_start();
        for (int i = 0; i < 4; i++) cmp(8'h70 + 8'(i), 8'h00, 8'h10, 4'd4, 1'b0);
        chk("prereset_valid", {31'd0, LOG_VALID}, 32'd1);
        #2;
        nRESET = 1'b0;
        #1;
        chk("arst_flags", {27'd0, LOG_VALID, OVERFLOW, BUSY, DONE, PASS}, 32'd0);
        chk("arst_cnt_first", {8'd0, FAIL_CNT, FIRST_ADDR}, 32'd0);
        chk("arst_log_data", {12'd0, LOG_DATA}, 32'd0);
        nRESET = 1'b1;
        cycle();
        chk("post_rst_idle", {30'd0, BUSY, DONE}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mbist_fail_log.md
Name: mbist_fail_log

Overview:
- Downstream of the MBIST controller. Consumes each read-compare event: address, expected data, actual SRAM data and algorithm phase (gen_Turn).
- Keeps a registered pass/fail verdict, a saturating fail count and the first failing address.
- Buffers failing entries in a small FIFO, drained by a valid/ready readout port for diagnosis after or during the test.

Parameters:
- ADDR_W, 8, SRAM address width
- DATA_W, 8, SRAM data width
- PHASE_W, 4, phase tag width (gen_Turn)
- DEPTH, 8, fail FIFO entries; power of 2, at least 2
- CNT_W, 16, fail counter width

Ports:
- CLK  in  1  clock, rising edge
- nRESET  in  1  asynchronous, active-low reset
- MBISTEN  in  1  MBIST enable; while low, compare events are ignored
- TEST_START  in  1  one-cycle pulse; clears verdict, counters and FIFO; enters RUN
- TEST_END  in  1  one-cycle pulse; RUN -> DONE
- CMP_VALID  in  1  compare event strobe, one event per asserted cycle
- CMP_ADDR  in  ADDR_W  address of the read
- CMP_EXP  in  DATA_W  expected data
- CMP_ACT  in  DATA_W  data read from SRAM
- CMP_PHASE  in  PHASE_W  gen_Turn value for the event
- LOG_VALID  out  1  FIFO non-empty
- LOG_READY  in  1  consumer accepts head entry
- LOG_DATA  out  PHASE_W+ADDR_W+DATA_W  head entry {phase, addr, syndrome = exp XOR act}
- FAIL_CNT  out  CNT_W  number of failing compares, saturating
- FIRST_ADDR  out  ADDR_W  address of the first failure since TEST_START
- OVERFLOW  out  1  sticky: a failure was dropped because the FIFO was full
- BUSY  out  1  state == RUN
- DONE  out  1  state == DONE
- PASS  out  1  DONE and FAIL_CNT == 0

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE. LOG_DATA reads 0 when empty.
- State machine: IDLE, RUN, DONE.
  - IDLE -> RUN on TEST_START & MBISTEN.
  - RUN -> DONE on TEST_END.
  - DONE -> RUN on TEST_START & MBISTEN.
  - Any state -> IDLE when MBISTEN is low; FAIL_CNT, FIRST_ADDR, OVERFLOW and FIFO contents are retained.
  - TEST_END outside RUN is ignored.
- TEST_START in RUN or DONE restarts: synchronously clears FAIL_CNT, FIRST_ADDR, OVERFLOW and the FIFO pointers in the same cycle. A CMP_VALID in that cycle is discarded.
- A compare is taken only when state == RUN, MBISTEN = 1 and CMP_VALID = 1. fail = (CMP_ACT != CMP_EXP), full data width compared.
- On a failing event:
  - FAIL_CNT increments, holding at 2^CNT_W - 1.
  - FIRST_ADDR loads CMP_ADDR only when FAIL_CNT == 0 before the event.
  - The entry is pushed if the FIFO is not full.
  - If the FIFO is full and no pop happens that cycle, the entry is dropped, OVERFLOW sets, and the count still increments.
- All updates take effect 1 cycle after the event edge. The verdict is visible the cycle after DONE is entered.
- TEST_END and CMP_VALID in the same cycle: the compare is processed, then DONE.
- FIFO:
  - LOG_VALID = count != 0. A pop occurs when LOG_VALID & LOG_READY.
  - Push and pop in the same cycle are both honoured, including when full; the count is unchanged.
  - LOG_DATA is the registered head entry, stable while LOG_VALID & !LOG_READY.
  - Readout works in every state, including IDLE with MBISTEN low.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Syndrome = CMP_EXP ^ CMP_ACT; non-zero for every logged entry.
- Asynchronous reset mid-test returns everything to reset values immediately.

Test Plan:
- Clean run: START; 256 compares with exp = act = 8'h55; END → DONE = 1, PASS = 1, FAIL_CNT = 0, LOG_VALID = 0.
- Single fail: START; addr 8'h3C, exp 8'h00, act 8'h04, phase 4'd2; END → FAIL_CNT = 1, FIRST_ADDR = 8'h3C, PASS = 0, LOG_DATA = {4'h2, 8'h3C, 8'h04}; LOG_READY = 1 → LOG_VALID = 0 next cycle.
- Overflow: DEPTH = 8; 10 failing compares at addr 0..9 with LOG_READY = 0 → FAIL_CNT = 10, OVERFLOW = 1; drained entries are addr 0..7 in order.
- Full with simultaneous push/pop: fill to 8; a fail at addr 8'hA0 with LOG_READY = 1 → no overflow, count stays 8, last entry drained is 8'hA0.
- Control corners: CMP_VALID in IDLE and in DONE → ignored. START while in DONE with FAIL_CNT = 3 → FAIL_CNT = 0 and FIFO empty next cycle. MBISTEN dropped mid-RUN → state IDLE with the log still readable.
- Reset: nRESET low for 1 ns mid-RUN with 4 logged fails → all outputs 0 immediately; after release, state IDLE.
